// File: rtl/sort_result_serializer_if.sv
// Handshake bundle between the sorter, the serializer and the byte-wide link:
// triple input, serialized output and frame status.
interface sort_result_serializer_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] max_i;
    logic [DATA_W-1:0] med_i;
    logic [DATA_W-1:0] min_i;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic [CNT_W-1:0]  frame_cnt;
    logic              order_err;

    modport slave (
        input  in_valid, max_i, med_i, min_i, out_ready,
        output in_ready, out_valid, out_data, out_last, frame_cnt, order_err
    );

    modport master (
        output in_valid, max_i, med_i, min_i, out_ready,
        input  in_ready, out_valid, out_data, out_last, frame_cnt, order_err
    );
endinterface

// File: rtl/sort_result_serializer.sv
// Serializes sorted triples {max,med,min} into a byte stream, one value per beat.
// Optional feature: define ORDER_CHECK_EN to flag (sticky) any unsorted triple.
module sort_result_serializer #(
    parameter int DATA_W    = 8,
    parameter bit ASCENDING = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    sort_result_serializer_if.slave  bus
);
    localparam int TRI_W = 3 * DATA_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_B0   = 2'd1,
        ST_B1   = 2'd2,
        ST_B2   = 2'd3
    } state_t;

    // Triples are packed as {max, med, min}; idx is the beat slot 0..2.
    function automatic logic [DATA_W-1:0] slot_sel(input logic [TRI_W-1:0] t,
                                                   input logic [1:0]       idx);
        logic [DATA_W-1:0] r;
        case (idx)
            2'd0:    r = ASCENDING ? t[DATA_W-1:0] : t[TRI_W-1 -: DATA_W];
            2'd1:    r = t[2*DATA_W-1 -: DATA_W];
            default: r = ASCENDING ? t[TRI_W-1 -: DATA_W] : t[DATA_W-1:0];
        endcase
        return r;
    endfunction

    state_t             state_r, state_s;
    logic [TRI_W-1:0]   act_r, act_s;
    logic [TRI_W-1:0]   pend_r, pend_s;
    logic               pend_full_r, pend_full_s;
    logic               in_ready_r;
    logic               out_valid_r, out_valid_s;
    logic [DATA_W-1:0]  out_data_r, out_data_s;
    logic               out_last_r, out_last_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic [TRI_W-1:0]   in_tri_s;
    logic               accept_s;
    logic               beat_done_s;

    assign in_tri_s    = {bus.max_i, bus.med_i, bus.min_i};
    assign accept_s    = bus.in_valid && in_ready_r;
    assign beat_done_s = out_valid_r && bus.out_ready;

    // Next-state, storage and registered-output computation.
    always_comb begin
        state_s     = state_r;
        act_s       = act_r;
        pend_s      = pend_r;
        pend_full_s = pend_full_r;
        out_valid_s = out_valid_r;
        out_data_s  = out_data_r;
        out_last_s  = out_last_r;
        cnt_s       = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    act_s       = in_tri_s;
                    state_s     = ST_B0;
                    out_valid_s = 1'b1;
                    out_data_s  = slot_sel(in_tri_s, 2'd0);
                    out_last_s  = 1'b0;
                end else begin
                    out_valid_s = 1'b0;
                end
            end
            ST_B0, ST_B1: begin
                if (beat_done_s) begin
                    state_s    = (state_r == ST_B0) ? ST_B1 : ST_B2;
                    out_data_s = slot_sel(act_r, (state_r == ST_B0) ? 2'd1 : 2'd2);
                    out_last_s = (state_r == ST_B1);
                end else begin
                    state_s = state_r;
                end
                if (accept_s) begin
                    pend_s      = in_tri_s;
                    pend_full_s = 1'b1;
                end else begin
                    pend_full_s = pend_full_r;
                end
            end
            ST_B2: begin
                if (beat_done_s) begin
                    cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    // A waiting triple (pending first, then live input) keeps the stream gapless.
                    if (pend_full_r) begin
                        act_s       = pend_r;
                        pend_full_s = 1'b0;
                        state_s     = ST_B0;
                        out_data_s  = slot_sel(pend_r, 2'd0);
                        out_last_s  = 1'b0;
                    end else if (accept_s) begin
                        act_s      = in_tri_s;
                        state_s    = ST_B0;
                        out_data_s = slot_sel(in_tri_s, 2'd0);
                        out_last_s = 1'b0;
                    end else begin
                        state_s     = ST_IDLE;
                        out_valid_s = 1'b0;
                        out_last_s  = 1'b0;
                    end
                end else if (accept_s) begin
                    pend_s      = in_tri_s;
                    pend_full_s = 1'b1;
                end else begin
                    state_s = ST_B2;
                end
            end
            default: begin
                state_s     = ST_IDLE;
                out_valid_s = 1'b0;
                out_last_s  = 1'b0;
            end
        endcase
    end

    // State, storage and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            act_r       <= {TRI_W{1'b0}};
            pend_r      <= {TRI_W{1'b0}};
            pend_full_r <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_data_r  <= {DATA_W{1'b0}};
            out_last_r  <= 1'b0;
            cnt_r       <= {CNT_W{1'b0}};
        end else begin
            state_r     <= state_s;
            act_r       <= act_s;
            pend_r      <= pend_s;
            pend_full_r <= pend_full_s;
            in_ready_r  <= !pend_full_s;
            out_valid_r <= out_valid_s;
            out_data_r  <= out_data_s;
            out_last_r  <= out_last_s;
            cnt_r       <= cnt_s;
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_last  = out_last_r;
    assign bus.frame_cnt = cnt_r;

`ifdef ORDER_CHECK_EN
    function automatic logic order_bad(input logic [TRI_W-1:0] t);
        return !((t[TRI_W-1 -: DATA_W] >= t[2*DATA_W-1 -: DATA_W]) &&
                 (t[2*DATA_W-1 -: DATA_W] >= t[DATA_W-1:0]));
    endfunction

    logic order_err_r;

    // Sticky flag for any accepted triple that is not max>=med>=min.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            order_err_r <= 1'b0;
        end else if (accept_s && order_bad(in_tri_s)) begin
            order_err_r <= 1'b1;
        end else begin
            order_err_r <= order_err_r;
        end
    end

    assign bus.order_err = order_err_r;
`else
    assign bus.order_err = 1'b0;
`endif
endmodule

// File: tb/tb_sort_result_serializer.sv
// Self-checking bench: scoreboard of expected beats for an ascending 16-bit-count
// instance (dut_a) and a descending 2-bit-count instance (dut_b).
module tb_sort_result_serializer;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    sort_result_serializer_if #(.DATA_W(8), .CNT_W(16)) ifa ();
    sort_result_serializer_if #(.DATA_W(8), .CNT_W(2))  ifb ();

    sort_result_serializer #(.DATA_W(8), .ASCENDING(1'b1), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa.slave));
    sort_result_serializer #(.DATA_W(8), .ASCENDING(1'b0), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb.slave));

    int vectors     = 0;
    int miscompares = 0;
    logic [8:0] exp_a[$];
    logic [8:0] exp_b[$];
    logic [8:0] e_a, e_b;

`ifdef ORDER_CHECK_EN
    localparam logic ORDER_EXP = 1'b1;
`else
    localparam logic ORDER_EXP = 1'b0;
`endif

    // Scoreboard for dut_a: every completed beat pops one expected {last,data}.
    always @(negedge clk) begin
        if (!rst && ifa.out_valid && ifa.out_ready) begin
            vectors++;
            if (exp_a.size() == 0) begin
                miscompares++;
                $display("FAIL beat_a: got unexpected beat data=%0d last=%0b, required no beat",
                         ifa.out_data, ifa.out_last);
            end else begin
                e_a = exp_a.pop_front();
                if ({ifa.out_last, ifa.out_data} !== e_a) begin
                    miscompares++;
                    $display("FAIL beat_a: got data=%0d last=%0b, required data=%0d last=%0b",
                             ifa.out_data, ifa.out_last, e_a[7:0], e_a[8]);
                end
            end
        end
    end

    // Scoreboard for dut_b.
    always @(negedge clk) begin
        if (!rst && ifb.out_valid && ifb.out_ready) begin
            vectors++;
            if (exp_b.size() == 0) begin
                miscompares++;
                $display("FAIL beat_b: got unexpected beat data=%0d last=%0b, required no beat",
                         ifb.out_data, ifb.out_last);
            end else begin
                e_b = exp_b.pop_front();
                if ({ifb.out_last, ifb.out_data} !== e_b) begin
                    miscompares++;
                    $display("FAIL beat_b: got data=%0d last=%0b, required data=%0d last=%0b",
                             ifb.out_data, ifb.out_last, e_b[7:0], e_b[8]);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic push_a(input logic [7:0] mx, input logic [7:0] md, input logic [7:0] mn);
        exp_a.push_back({1'b0, mn});
        exp_a.push_back({1'b0, md});
        exp_a.push_back({1'b1, mx});
    endtask

    // Caller sits at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send_a(input logic [7:0] mx, input logic [7:0] md, input logic [7:0] mn);
        int n = 0;
        while (ifa.in_ready !== 1'b1 && n < 64) begin
            @(posedge clk); #1; n++;
        end
        vectors++;
        if (ifa.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL send_a_ready: got in_ready=%0b, required 1 within 64 cycles", ifa.in_ready);
        end
        ifa.in_valid = 1'b1;
        ifa.max_i = mx; ifa.med_i = md; ifa.min_i = mn;
        push_a(mx, md, mn);
        @(posedge clk); #1;
        ifa.in_valid = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] mx, input logic [7:0] md, input logic [7:0] mn);
        int n = 0;
        while (ifb.in_ready !== 1'b1 && n < 64) begin
            @(posedge clk); #1; n++;
        end
        vectors++;
        if (ifb.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL send_b_ready: got in_ready=%0b, required 1 within 64 cycles", ifb.in_ready);
        end
        ifb.in_valid = 1'b1;
        ifb.max_i = mx; ifb.med_i = md; ifb.min_i = mn;
        exp_b.push_back({1'b0, mx});
        exp_b.push_back({1'b0, md});
        exp_b.push_back({1'b1, mn});
        @(posedge clk); #1;
        ifb.in_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_a.size() != 0 || exp_b.size() != 0 ||
                ifa.out_valid !== 1'b0 || ifb.out_valid !== 1'b0) && n < budget) begin
            @(posedge clk); #1; n++;
        end
        vectors++;
        if (exp_a.size() != 0 || exp_b.size() != 0 || ifa.out_valid !== 1'b0 || ifb.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL drain: got %0d/%0d beats outstanding, valid=%0b/%0b, required all drained",
                     exp_a.size(), exp_b.size(), ifa.out_valid, ifb.out_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ifa.in_valid = 1'b0; ifa.max_i = 8'd0; ifa.med_i = 8'd0; ifa.min_i = 8'd0; ifa.out_ready = 1'b1;
        ifb.in_valid = 1'b0; ifb.max_i = 8'd0; ifb.med_i = 8'd0; ifb.min_i = 8'd0; ifb.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if ({ifa.out_valid, ifa.in_ready, ifa.out_last, ifa.order_err} !== 4'b0100) begin
            miscompares++;
            $display("FAIL reset_flags: got valid/ready/last/err=%b%b%b%b, required 0100",
                     ifa.out_valid, ifa.in_ready, ifa.out_last, ifa.order_err);
        end
        vectors++;
        if (ifa.frame_cnt !== 16'd0 || ifa.out_data !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_vals: got frame_cnt=%0d out_data=%0d, required 0 and 0",
                     ifa.frame_cnt, ifa.out_data);
        end
        vectors++;
        if (ifb.out_valid !== 1'b0 || ifb.in_ready !== 1'b1 || ifb.frame_cnt !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_b: got valid=%0b ready=%0b cnt=%0d, required 0 1 0",
                     ifb.out_valid, ifb.in_ready, ifb.frame_cnt);
        end
    endtask

    task automatic test_basic();
        send_a(8'd3, 8'd2, 8'd1);
        vectors++;
        if (ifa.out_valid !== 1'b1 || ifa.out_data !== 8'd1 || ifa.out_last !== 1'b0) begin
            miscompares++;
            $display("FAIL first_beat_latency: got valid=%0b data=%0d last=%0b, required 1 1 0",
                     ifa.out_valid, ifa.out_data, ifa.out_last);
        end
        repeat (3) begin @(posedge clk); #1; end
        vectors++;
        if (ifa.frame_cnt !== 16'd1 || ifa.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_frame_cnt: got cnt=%0d valid=%0b, required 1 0",
                     ifa.frame_cnt, ifa.out_valid);
        end
        drain(20);
    endtask

    task automatic test_back_to_back();
        logic [15:0] base;
        base = ifa.frame_cnt;
        send_a(8'd8, 8'd6, 8'd4);
        send_a(8'd15, 8'd13, 8'd11);
        vectors++;
        if (ifa.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_pending_ready: got in_ready=%0b, required 0", ifa.in_ready);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if (ifa.out_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL b2b_no_bubble: got out_valid=0 at stream cycle %0d, required 1", i + 2);
            end
        end
        @(negedge clk);
        vectors++;
        if (ifa.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_stream_end: got out_valid=%0b, required 0", ifa.out_valid);
        end
        @(posedge clk); #1;
        vectors++;
        if (ifa.frame_cnt !== base + 16'd2) begin
            miscompares++;
            $display("FAIL b2b_frame_cnt: got %0d, required %0d", ifa.frame_cnt, base + 16'd2);
        end
        drain(20);
    endtask

    task automatic test_backpressure();
        logic [15:0] base;
        base = ifa.frame_cnt;
        send_a(8'd3, 8'd2, 8'd1);
        @(posedge clk); #1;
        ifa.out_ready = 1'b0;
        ifa.in_valid = 1'b1;
        ifa.max_i = 8'd9; ifa.med_i = 8'd7; ifa.min_i = 8'd5;
        push_a(8'd9, 8'd7, 8'd5);
        @(posedge clk); #1;
        ifa.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (ifa.out_valid !== 1'b1 || ifa.out_data !== 8'd2 || ifa.out_last !== 1'b0 || ifa.in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_hold: cycle %0d got valid=%0b data=%0d last=%0b ready=%0b, required 1 2 0 0",
                         i, ifa.out_valid, ifa.out_data, ifa.out_last, ifa.in_ready);
            end
            if (i < 4) begin
                @(posedge clk); #1;
            end
        end
        ifa.out_ready = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (ifa.in_ready !== 1'b0 || ifa.out_data !== 8'd3 || ifa.out_last !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_b2: got ready=%0b data=%0d last=%0b, required 0 3 1",
                     ifa.in_ready, ifa.out_data, ifa.out_last);
        end
        @(posedge clk); #1;
        vectors++;
        if (ifa.in_ready !== 1'b1 || ifa.out_data !== 8'd5) begin
            miscompares++;
            $display("FAIL bp_release: got ready=%0b data=%0d, required 1 5", ifa.in_ready, ifa.out_data);
        end
        drain(20);
        vectors++;
        if (ifa.frame_cnt !== base + 16'd2) begin
            miscompares++;
            $display("FAIL bp_frame_cnt: got %0d, required %0d", ifa.frame_cnt, base + 16'd2);
        end
    endtask

    task automatic test_reset_midframe();
        send_a(8'd3, 8'd2, 8'd1);
        @(posedge clk); #1;
        #1 rst = 1'b1;
        #1;
        vectors++;
        if (ifa.out_valid !== 1'b0 || ifa.frame_cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL rst_async: got valid=%0b cnt=%0d, required 0 0", ifa.out_valid, ifa.frame_cnt);
        end
        exp_a.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++;
            if (ifa.out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL rst_residual: got out_valid=1 %0d cycles after reset, required 0", i);
            end
        end
        @(posedge clk); #1;
        send_a(8'd30, 8'd20, 8'd10);
        drain(20);
        vectors++;
        if (ifa.frame_cnt !== 16'd1) begin
            miscompares++;
            $display("FAIL rst_resume_cnt: got %0d, required 1", ifa.frame_cnt);
        end
    endtask

    task automatic test_descending_wrap();
        logic [1:0] cnt_exp;
        logic [7:0] v;
        send_b(8'd200, 8'd100, 8'd7);
        drain(20);
        cnt_exp = 2'd1;
        vectors++;
        if (ifb.frame_cnt !== cnt_exp) begin
            miscompares++;
            $display("FAIL desc_cnt: got %0d, required %0d", ifb.frame_cnt, cnt_exp);
        end
        for (int k = 0; k < 3; k++) begin
            v = 8'($urandom_range(0, 80));
            send_b(v + 8'd170, v + 8'd90, v);
            drain(20);
            cnt_exp = cnt_exp + 2'd1;
            vectors++;
            if (ifb.frame_cnt !== cnt_exp) begin
                miscompares++;
                $display("FAIL desc_wrap_cnt: frame %0d got %0d, required %0d", k + 2, ifb.frame_cnt, cnt_exp);
            end
        end
    endtask

    task automatic test_order_check();
        send_a(8'd5, 8'd9, 8'd1);
        vectors++;
        if (ifa.order_err !== ORDER_EXP) begin
            miscompares++;
            $display("FAIL order_err_set: got %0b, required %0b", ifa.order_err, ORDER_EXP);
        end
        drain(20);
        send_a(8'd3, 8'd2, 8'd1);
        drain(20);
        vectors++;
        if (ifa.order_err !== ORDER_EXP) begin
            miscompares++;
            $display("FAIL order_err_sticky: got %0b, required %0b", ifa.order_err, ORDER_EXP);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_reset_midframe();
        test_descending_wrap();
        test_order_check();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
